dds_sweep_scheduler: RTL and testbench
======================================

# dds_sweep_scheduler

Chirp sequencer that drives the AD9910 trigger/timing block. It latches a host-supplied chirp configuration and issues periodic `io_update` pulses at a programmed repetition period. It presents a stable `triger_pulse`/`sweep_sel` pair for each chirp and tracks DDS `drover` completion. It counts chirps, stops on a count limit or host request, and flags a missing `drover` response with a watchdog.

## Interface
Parameters:
- `IOUP_WIDTH`, 8: `io_update` high time in `sys_clk` cycles (≥1).
- `PERIOD_W`, 32: width of the repetition period counter.
- `TIMEOUT`, 65535: cycles allowed between `io_update` rise and `drover` fall.

Ports:
- `sys_clk`, in, 1: 500 MHz system clock.
- `sys_rst`, in, 1: reset, asynchronous, active-high.
- `cfg_valid`, in, 1: configuration offer.
- `cfg_ready`, out, 1: high only in IDLE; transfer occurs on `cfg_valid & cfg_ready`.
- `cfg_period`, in, `PERIOD_W`: cycles between successive `io_update` rising edges.
- `cfg_pulse`, in, 16: chirp pulse width in ns.
- `cfg_count`, in, 16: chirps per run; 0 means continuous.
- `cfg_sweep_sel`, in, 1: initial sweep direction.
- `start`, in, 1: one-cycle run request.
- `stop`, in, 1: one-cycle graceful stop request.
- `drover`, in, 1: DDS digital-ramp-over pin, asynchronous.
- `io_update`, out, 1: DDS IO_UPDATE.
- `triger_pulse`, out, 16: pulse width to the timing block.
- `sweep_sel`, out, 1: sweep direction to the timing block.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse on return to IDLE from a run.
- `chirp_cnt`, out, 16: chirps completed in the current or last run.
- `overrun`, out, 1: sticky; `drover` fell after the period had elapsed.
- `err_timeout`, out, 1: sticky; watchdog expired.

## Operation
- Shadow registers (`period`, `pulse`, `count`, `sel`) load on a cfg handshake.
- Reset values: all shadows 0 and `sel` 0.
- States: IDLE, UPDATE, WAIT_FALL, WAIT_PERIOD.
- IDLE, on `start`:
  - If shadow `pulse` ≠ 0: go to UPDATE, copy `pulse`→`triger_pulse` and `sel`→`sweep_sel`, clear `chirp_cnt`, `overrun`, `err_timeout` and `stop_req`.
  - If shadow `pulse` = 0: `start` is ignored.
- UPDATE: `io_update` is high for `IOUP_WIDTH` cycles. The period counter and the watchdog reset on entry. Then go to WAIT_FALL.
- WAIT_FALL:
  - Synchronized `drover` falling edge: increment `chirp_cnt` (saturating at 0xFFFF), then go to WAIT_PERIOD.
  - Watchdog reaches `TIMEOUT`: set `err_timeout`, go to IDLE, pulse `done`.
- WAIT_PERIOD: when the period counter reaches the effective period, the next state is decided as follows.
  - Go to IDLE and pulse `done` if `stop_req` is set, or if `count` ≠ 0 and `chirp_cnt` == `count`.
  - Otherwise go to UPDATE.
- If the `drover` fall arrives after the period counter has already reached the period: set `overrun` and enter UPDATE on the next cycle.
- Effective period = max(`period`, 2·`IOUP_WIDTH`).
- `stop` while busy sets `stop_req`; `stop` in IDLE has no effect. `start` while busy is ignored.
- `start` and `cfg_valid` in the same IDLE cycle: the config loads first, and the run uses the new values.
- Reset mid-run: all outputs go to their reset values immediately. Nothing resumes after reset.
- Output reset values: `io_update` 0, `triger_pulse` 0, `sweep_sel` 0, `busy` 0, `done` 0, `chirp_cnt` 0, `overrun` 0, `err_timeout` 0, `cfg_ready` 0 while in reset and 1 afterwards.

## Timing
- `io_update` rises on the first clock edge after the `start` cycle and is registered.
- Without overrun, `io_update` rising edges are exactly the effective period apart.
- `drover` passes through a 2-FF synchronizer plus an edge register. A pin fall is recognized 3 cycles later.
- `triger_pulse` and `sweep_sel` change only on the IDLE→UPDATE edge, or the WAIT_PERIOD→UPDATE edge when alternation is enabled. They are never changed mid-chirp.
- `done` is asserted in the same cycle the state returns to IDLE.

## Configuration
- Macro: `DDS_SWEEP_ALT_EN`.
- Defined: `sweep_sel` toggles on every WAIT_PERIOD→UPDATE transition, giving alternating up/down chirps starting from `sel`.
- Undefined: `sweep_sel` holds `sel` for the whole run.

## Structure
- Shared package `dds_sched_pkg` holds:
  - state encoding localparams;
  - the default `IOUP_WIDTH` and `TIMEOUT` constants.
- Sub-module `sync_edge_det` contains the 2-FF synchronizer and falling-edge detector for `drover`. Its reset is asynchronous and active-high.

## Test plan
- Continuous repetition: config period=1000, pulse=1000, count=3, sel=0; start; `drover` falls 200 cycles after each `io_update`. Required: 3 `io_update` pulses, each 8 cycles wide, rises 1000 cycles apart; `chirp_cnt`=3; `done` pulses; `triger_pulse`=1000 throughout.
- Alternation: with `DDS_SWEEP_ALT_EN`, count=4, sel=1. Required: `sweep_sel` sequence 1,0,1,0. Without the macro: 1,1,1,1.
- Stop: count=0, `stop` pulsed during chirp 2. Required: chirp 2 completes, no third `io_update`, `done` pulses, `chirp_cnt`=2.
- Watchdog: `drover` held high, TIMEOUT=100. Required: `err_timeout`=1 about 100 cycles after `io_update` rise, then IDLE with `done`.
- Overrun and clamp: period=10 (clamped to 16), `drover` falls 40 cycles after each `io_update`. Required: `overrun`=1; next `io_update` rises 4 cycles after the pin fall.
- Reset mid-WAIT_FALL, plus a pulse=0 start. Required: after reset all outputs are 0 and `cfg_ready`=1; `start` with pulse=0 leaves `busy`=0.

Source files
------------

// File: rtl/dds_sched_pkg.sv
// Shared state encoding and default timing constants for the DDS chirp sequencer.
// Pure definitions: no logic, no latency, no flow control.
package dds_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE        = 2'd0;
  localparam state_t S_UPDATE      = 2'd1;
  localparam state_t S_WAIT_FALL   = 2'd2;
  localparam state_t S_WAIT_PERIOD = 2'd3;

  localparam int IOUP_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF    = 65535;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchronizer plus registered falling-edge detector for an asynchronous pin.
// Latency: a pin fall appears as a one-cycle o_fall pulse 3 clocks later; no backpressure.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;
  logic r_fall;

  // Reset to low so a pin already high at reset release never looks like a fall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_meta   <= i_d;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      r_fall   <= r_sync_q & ~r_sync;
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/dds_sweep_scheduler.sv
// AD9910 chirp sequencer: registered io_update one edge after start, rises every effective period.
// cfg accepted only in IDLE (cfg_ready); DDS_SWEEP_ALT_EN makes sweep_sel alternate chirp to chirp.
module dds_sweep_scheduler
  import dds_sched_pkg::*;
#(
  parameter int IOUP_WIDTH = IOUP_WIDTH_DEF,
  parameter int PERIOD_W   = 32,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [15:0]         cfg_pulse,
  input  logic [15:0]         cfg_count,
  input  logic                cfg_sweep_sel,
  input  logic                start,
  input  logic                stop,
  input  logic                drover,
  output logic                io_update,
  output logic [15:0]         triger_pulse,
  output logic                sweep_sel,
  output logic                busy,
  output logic                done,
  output logic [15:0]         chirp_cnt,
  output logic                overrun,
  output logic                err_timeout
);

  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * IOUP_WIDTH);
  localparam logic [PERIOD_W-1:0] IOUP_LAST  = PERIOD_W'(IOUP_WIDTH - 1);
  localparam logic [PERIOD_W-1:0] ONE_P      = PERIOD_W'(1);
  localparam logic [31:0]         WDOG_LAST  = 32'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [PERIOD_W-1:0] r_period;
  logic [15:0]         r_pulse;
  logic [15:0]         r_count;
  logic                r_sel;
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [31:0]         r_wdog;
  logic                r_stop_req;
  logic                r_io_update;
  logic                r_done;
  logic [15:0]         r_triger;
  logic                r_sweep_sel;
  logic [15:0]         r_chirp_cnt;
  logic                r_overrun;
  logic                r_err_timeout;

  logic                w_busy;
  logic                w_cfg_ready;
  logic                w_cfg_hs;
  logic [15:0]         w_pulse_new;
  logic                w_sel_new;
  logic                w_sel_step;
  logic                w_fall;
  logic [PERIOD_W-1:0] w_per_eff;
  logic                w_per_done;
  logic                w_wdog_exp;
  logic [15:0]         w_cnt_inc;
  logic                w_limit_hit;
  logic                w_limit_hit_inc;
  logic                w_enter_upd;
  logic                w_rerun;
  logic                w_launch;

  sync_edge_det u_drover_sync (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_d    (drover),
    .o_fall (w_fall)
  );

  // A same-cycle cfg handshake overrides the shadows so start uses the new values.
  assign w_cfg_hs    = cfg_valid & w_cfg_ready;
  assign w_pulse_new = w_cfg_hs ? cfg_pulse : r_pulse;
  assign w_sel_new   = w_cfg_hs ? cfg_sweep_sel : r_sel;

  assign w_per_eff       = (r_period < MIN_PERIOD) ? MIN_PERIOD : r_period;
  assign w_per_done      = (r_per_cnt >= (w_per_eff - ONE_P));
  assign w_wdog_exp      = (r_wdog >= WDOG_LAST);
  assign w_cnt_inc       = (r_chirp_cnt == 16'hFFFF) ? r_chirp_cnt : r_chirp_cnt + 16'd1;
  assign w_limit_hit     = (r_count != 16'd0) && (r_chirp_cnt == r_count);
  assign w_limit_hit_inc = (r_count != 16'd0) && (w_cnt_inc == r_count);

`ifdef DDS_SWEEP_ALT_EN
  assign w_sel_step = ~r_sweep_sel;
`else
  assign w_sel_step = r_sweep_sel;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && (w_pulse_new != 16'd0)) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        if (r_per_cnt >= IOUP_LAST) w_next = S_WAIT_FALL;
      end
      S_WAIT_FALL: begin
        // A late drover fall (period already elapsed) skips WAIT_PERIOD entirely.
        if (w_fall) begin
          if (!w_per_done)                         w_next = S_WAIT_PERIOD;
          else if (r_stop_req || w_limit_hit_inc)  w_next = S_IDLE;
          else                                     w_next = S_UPDATE;
        end else if (w_wdog_exp) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT_PERIOD: begin
        if (w_per_done) w_next = (r_stop_req || w_limit_hit) ? S_IDLE : S_UPDATE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_cfg_ready = (r_state == S_IDLE) && !sys_rst;
    w_enter_upd = (w_next == S_UPDATE) && (r_state != S_UPDATE);
    w_rerun     = (r_state == S_WAIT_PERIOD) && (w_next == S_UPDATE);
    w_launch    = (r_state == S_IDLE) && (w_next == S_UPDATE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_period      <= '0;
      r_pulse       <= 16'd0;
      r_count       <= 16'd0;
      r_sel         <= 1'b0;
      r_per_cnt     <= '0;
      r_wdog        <= 32'd0;
      r_stop_req    <= 1'b0;
      r_io_update   <= 1'b0;
      r_done        <= 1'b0;
      r_triger      <= 16'd0;
      r_sweep_sel   <= 1'b0;
      r_chirp_cnt   <= 16'd0;
      r_overrun     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_cfg_hs) begin
        r_period <= cfg_period;
        r_pulse  <= cfg_pulse;
        r_count  <= cfg_count;
        r_sel    <= cfg_sweep_sel;
      end

      r_io_update <= (w_next == S_UPDATE);
      r_done      <= (r_state != S_IDLE) && (w_next == S_IDLE);

      // Period counter and watchdog both measure cycles since the io_update rise.
      if (w_enter_upd) begin
        r_per_cnt <= '0;
        r_wdog    <= 32'd0;
      end else begin
        if (!w_per_done) r_per_cnt <= r_per_cnt + ONE_P;
        if (!w_wdog_exp) r_wdog    <= r_wdog + 32'd1;
      end

      if (w_launch) begin
        r_triger      <= w_pulse_new;
        r_sweep_sel   <= w_sel_new;
        r_chirp_cnt   <= 16'd0;
        r_overrun     <= 1'b0;
        r_err_timeout <= 1'b0;
        r_stop_req    <= 1'b0;
      end else begin
        if (stop && w_busy) r_stop_req <= 1'b1;
        if (w_rerun)        r_sweep_sel <= w_sel_step;
        if ((r_state == S_WAIT_FALL) && w_fall) begin
          r_chirp_cnt <= w_cnt_inc;
          if (w_per_done) r_overrun <= 1'b1;
        end
        if ((r_state == S_WAIT_FALL) && !w_fall && w_wdog_exp) r_err_timeout <= 1'b1;
      end
    end
  end

  assign cfg_ready    = w_cfg_ready;
  assign busy         = w_busy;
  assign io_update    = r_io_update;
  assign done         = r_done;
  assign triger_pulse = r_triger;
  assign sweep_sel    = r_sweep_sel;
  assign chirp_cnt    = r_chirp_cnt;
  assign overrun      = r_overrun;
  assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Directed bench for dds_sweep_scheduler: repetition, alternation, stop, watchdog, overrun, reset.
`timescale 1ns/1ps
module tb_dds_sweep_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic [15:0] cfg_pulse = 16'd0;
  logic [15:0] cfg_count = 16'd0;
  logic        cfg_sweep_sel = 1'b0;
  logic        start = 1'b0;
  logic        wd_start = 1'b0;
  logic        stop = 1'b0;
  logic        drover = 1'b0;

  logic        cfg_ready, io_update, sweep_sel, busy, done, overrun, err_timeout;
  logic [15:0] triger_pulse, chirp_cnt;
  logic        wd_cfg_ready, wd_io_update, wd_sweep_sel, wd_busy, wd_done, wd_overrun, wd_err;
  logic [15:0] wd_triger, wd_chirp_cnt;

  dds_sweep_scheduler u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_pulse(cfg_pulse), .cfg_count(cfg_count),
    .cfg_sweep_sel(cfg_sweep_sel), .start(start), .stop(stop), .drover(drover),
    .io_update(io_update), .triger_pulse(triger_pulse), .sweep_sel(sweep_sel), .busy(busy),
    .done(done), .chirp_cnt(chirp_cnt), .overrun(overrun), .err_timeout(err_timeout)
  );

  dds_sweep_scheduler #(.TIMEOUT(100)) u_wd (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(wd_cfg_ready),
    .cfg_period(cfg_period), .cfg_pulse(cfg_pulse), .cfg_count(cfg_count),
    .cfg_sweep_sel(cfg_sweep_sel), .start(wd_start), .stop(stop), .drover(drover),
    .io_update(wd_io_update), .triger_pulse(wd_triger), .sweep_sel(wd_sweep_sel), .busy(wd_busy),
    .done(wd_done), .chirp_cnt(wd_chirp_cnt), .overrun(wd_overrun), .err_timeout(wd_err)
  );

  always #1 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observers: io_update rise stamps/widths, sweep_sel at each rise, done pulses, pulse stability.
  int          cyc = 0;
  int          rise_q[$];
  int          width_q[$];
  logic        sel_q[$];
  int          done_cnt = 0;
  int          bad_pulse = 0;
  int          cur_w = 0;
  logic        io_prev = 1'b0;
  logic [15:0] exp_pulse = 16'd0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (io_update && !io_prev) begin
      rise_q.push_back(cyc);
      sel_q.push_back(sweep_sel);
    end
    if (io_update) cur_w++;
    else if (io_prev) begin
      width_q.push_back(cur_w);
      cur_w = 0;
    end
    if (done) done_cnt++;
    if (busy && (triger_pulse !== exp_pulse)) bad_pulse++;
    io_prev = io_update;
  end

  // DDS model: drover goes high at each io_update rise and falls drv_delay cycles later.
  int drv_delay = 0;
  always begin
    @(posedge io_update);
    if (drv_delay != 0) begin
      drover = 1'b1;
      repeat (drv_delay) @(negedge sys_clk);
      drover = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_obs();
    rise_q.delete();
    width_q.delete();
    sel_q.delete();
    done_cnt  = 0;
    bad_pulse = 0;
  endtask

  task automatic send_cfg(input logic [31:0] per, input logic [15:0] pul, input logic [15:0] cnt,
                          input logic sel, input logic with_start);
    cfg_valid     = 1'b1;
    cfg_period    = per;
    cfg_pulse     = pul;
    cfg_count     = cnt;
    cfg_sweep_sel = sel;
    start         = with_start;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  initial begin
    logic [31:0] exp_sel;
    int n;

    cycles(2);
    check("rst_outputs", 32'({io_update, sweep_sel, busy, done, overrun, err_timeout, cfg_ready}), 32'd0);
    check("rst_triger", 32'(triger_pulse), 32'd0);
    check("rst_chirp_cnt", 32'(chirp_cnt), 32'd0);
    sys_rst = 1'b0;
    cycles(1);
    check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Repetition, with cfg and start in the same cycle.
    clear_obs();
    exp_pulse = 16'd1000;
    drv_delay = 200;
    send_cfg(32'd1000, 16'd1000, 16'd3, 1'b0, 1'b1);
    check("rep_first_rise", 32'(io_update), 32'd1);
    check("rep_busy", 32'(busy), 32'd1);
    wait_done(3200);
    check("rep_done", 32'(done), 32'd1);
    cycles(2);
    check("rep_rises", 32'(rise_q.size()), 32'd3);
    check("rep_gap1", 32'(rise_q[1] - rise_q[0]), 32'd1000);
    check("rep_gap2", 32'(rise_q[2] - rise_q[1]), 32'd1000);
    for (int i = 0; i < 3; i++) check("rep_width", 32'(width_q[i]), 32'd8);
    check("rep_chirp_cnt", 32'(chirp_cnt), 32'd3);
    check("rep_done_cnt", 32'(done_cnt), 32'd1);
    check("rep_pulse_stable", 32'(bad_pulse), 32'd0);
    check("rep_no_overrun", 32'(overrun), 32'd0);
    check("rep_idle", 32'(busy), 32'd0);

    // Alternation (or hold) of sweep_sel across four chirps.
    clear_obs();
    exp_pulse = 16'd500;
    drv_delay = 20;
    send_cfg(32'd100, 16'd500, 16'd4, 1'b1, 1'b0);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_done(600);
    check("alt_done", 32'(done), 32'd1);
    cycles(2);
    check("alt_rises", 32'(rise_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef DDS_SWEEP_ALT_EN
      exp_sel = (i % 2 == 0) ? 32'd1 : 32'd0;
`else
      exp_sel = 32'd1;
`endif
      check("alt_sweep_sel", 32'(sel_q[i]), exp_sel);
    end
    check("alt_chirp_cnt", 32'(chirp_cnt), 32'd4);

    // Graceful stop during chirp 2 of a continuous run.
    clear_obs();
    exp_pulse = 16'd300;
    send_cfg(32'd100, 16'd300, 16'd0, 1'b0, 1'b1);
    cycles(110);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    wait_done(300);
    check("stop_done", 32'(done), 32'd1);
    cycles(150);
    check("stop_rises", 32'(rise_q.size()), 32'd2);
    check("stop_chirp_cnt", 32'(chirp_cnt), 32'd2);
    check("stop_done_cnt", 32'(done_cnt), 32'd1);
    check("stop_idle", 32'(busy), 32'd0);

    // Watchdog on the TIMEOUT=100 instance with drover stuck high.
    drover = 1'b1;
    send_cfg(32'd1000, 16'd5, 16'd0, 1'b0, 1'b0);
    wd_start = 1'b1;
    cycles(1);
    wd_start = 1'b0;
    check("wd_first_rise", 32'(wd_io_update), 32'd1);
    n = 0;
    while (wd_err !== 1'b1 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    check("wd_latency", 32'(n), 32'd100);
    check("wd_done", 32'(wd_done), 32'd1);
    check("wd_idle", 32'(wd_busy), 32'd0);
    drover = 1'b0;
    cycles(5);

    // Overrun with clamped period: effective 16, drover falls 40 cycles after each rise.
    clear_obs();
    exp_pulse = 16'd77;
    drv_delay = 40;
    send_cfg(32'd10, 16'd77, 16'd2, 1'b0, 1'b1);
    wait_done(200);
    check("ovr_done", 32'(done), 32'd1);
    cycles(2);
    check("ovr_rises", 32'(rise_q.size()), 32'd2);
    check("ovr_gap", 32'(rise_q[1] - rise_q[0]), 32'd43);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_chirp_cnt", 32'(chirp_cnt), 32'd2);

    // Reset in WAIT_FALL, then a start with the cleared (zero) pulse shadow.
    exp_pulse = 16'd7;
    drv_delay = 200;
    send_cfg(32'd1000, 16'd7, 16'd0, 1'b0, 1'b1);
    cycles(50);
    check("mid_busy", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    #0.5;
    check("mid_rst_outputs", 32'({io_update, sweep_sel, busy, done, overrun, err_timeout, cfg_ready}), 32'd0);
    check("mid_rst_triger", 32'(triger_pulse), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cycles(1);
    check("mid_cfg_ready", 32'(cfg_ready), 32'd1);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(3);
    check("zero_pulse_busy", 32'(busy), 32'd0);
    check("zero_pulse_ioup", 32'(io_update), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, observed %0d checks", n_chk);
    $fatal(1, "timeout");
  end

endmodule
